hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers of the MIPS core. It replaces single-cycle MULT/DIV evaluation with a 32-iteration shift-add multiplier and restoring divider, with sign pre/post-processing for the signed forms. It services MTHI/MTLO writes and MFHI/MFLO reads, and raises a stall to the pipeline when a read hits an in-flight operation.

## Interface
Parameters:
- none; datapath fixed at 32 bits, 64-bit product/accumulator, 32 iterations.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; wins over every other input in the same cycle
- start  in  1  issue request, sampled only when busy=0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- rs_val  in  32  operand A (multiplicand/dividend, or MTHI/MTLO data)
- rt_val  in  32  operand B (multiplier/divisor)
- rd_hilo  in  1  MFHI/MFLO in decode/execute this cycle
- sel_hi  in  1  1 selects HI, 0 selects LO for rdata
- busy  out  1  state != IDLE
- stall  out  1  rd_hilo & busy (combinational)
- done  out  1  one-cycle pulse: HI/LO just updated by MULT*/DIV*
- hi  out  32  HI register
- lo  out  32  LO register
- rdata  out  32  sel_hi ? hi : lo (combinational)

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, start=1:
  - op 0/1 -> MUL. Latch |A|, |B| for op 0; raw A, B for op 1. Record neg = sA ^ sB (op 0 only). Clear the 64-bit accumulator. Count = 0.
  - op 2/3 -> DIV. Latch |A|, |B| for op 2; raw for op 3. Record qneg = sA ^ sB and rneg = sA (op 2 only). Record dz = (B == 0). Remainder = 0, quotient = dividend.
  - op 4 -> hi <= rs_val. op 5 -> lo <= rs_val. Both complete in one edge, stay in IDLE, done stays 0.
  - op 6/7 -> ignored.
- MUL, one step per cycle:
  - if multiplier bit[count] = 1, add multiplicand << count into the 64-bit accumulator.
  - after count = 31 -> FIXUP.
- DIV, one restoring step per cycle:
  - {rem, quo} shifted left 1.
  - trial = rem − divisor (33-bit). If non-negative: rem = trial, quo[0] = 1.
  - after 32 steps -> FIXUP.
- FIXUP:
  - MUL: {hi, lo} <= neg ? −acc (64-bit two's complement) : acc.
  - DIV, dz=0: lo <= qneg ? −quo : quo; hi <= rneg ? −rem : rem.
  - DIV, dz=1: lo <= 0xFFFFFFFF, hi <= rs_val as latched at issue. Signed fixup is bypassed.
  - FIXUP -> IDLE. done = 1 in the following cycle.
- Width rules:
  - all signed magnitudes are formed as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap.
- start while busy: ignored, including MTHI/MTLO. The issuing stage must hold the instruction on busy.
- hi/lo are not modified during MUL/DIV iteration; they change only in FIXUP or on MTHI/MTLO.
- reset (any state, including mid-operation):
  - state = IDLE; hi = lo = 0; busy = 0; done = 0.
  - the in-flight operation is discarded.

## Timing
- Issue edge E0: state leaves IDLE, busy = 1 from the cycle after E0.
- Iterations occupy edges E1..E32; FIXUP is evaluated at edge E33, which writes hi/lo and returns to IDLE.
- busy is high for exactly 33 cycles.
- done is high for the 1 cycle after E33. A new start is accepted in that same cycle.
- MTHI/MTLO: register visible the cycle after the issue edge. busy never asserts.
- rdata/stall are combinational from current registers. An MFHI in the done cycle reads the new value with stall = 0.
- Back-to-back MULT: the second start, presented in the done cycle, issues immediately. Throughput is 1 op per 34 cycles.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 -> after 33 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle.
- MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0, lo=1.
- DIV A=0xFFFFFFF9 (−7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 busy cycles. No X on any output.
- Hazard and drop checks:
  - MULT issued, then rd_hilo=1 every cycle -> stall=1 for 33 cycles, stall=0 in the done cycle with the new rdata.
  - MTHI 0xAAAA5555 issued mid-operation -> ignored; hi holds the product.
- Reset and MT writes:
  - reset asserted at iteration 10 of DIV -> next cycle busy=0, hi=lo=0, done never pulses.
  - MTLO 0x5 then start=1 with reset=1 in the same cycle -> lo=0, state IDLE.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the MIPS core: 32-step shift-add multiply and restoring divide,
// with sign pre/post-processing, MTHI/MTLO writes and MFHI/MFLO hazard stall.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hilo,
    input  logic        sel_hi,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 64;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              issue_mul;
    logic              issue_div;
    logic              issue_signed;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [ACC_W-1:0]  mul_addend;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [ACC_W-1:0]  prod_neg;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Magnitude as a 32-bit unsigned value; 0x80000000 maps to itself.
    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + XLEN'(1)) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            araw_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            araw_q   <= araw_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign issue_mul    = start && ((op == OP_MULT) || (op == OP_MULTU));
    assign issue_div    = start && ((op == OP_DIV)  || (op == OP_DIVU));
    assign issue_signed = (op == OP_MULT) || (op == OP_DIV);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (issue_mul) begin
                    state_d = S_MUL;
                end else if (issue_div) begin
                    state_d = S_DIV;
                end
            end
            S_MUL:   if (cnt_q == LAST_STEP) state_d = S_FIXUP;
            S_DIV:   if (cnt_q == LAST_STEP) state_d = S_FIXUP;
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_mag      = issue_signed ? abs32(rs_val) : rs_val;
        b_mag      = issue_signed ? abs32(rt_val) : rt_val;
        mul_addend = opb_q[cnt_q] ? (ACC_W'(opa_q) << cnt_q) : '0;
        // acc holds {rem, quo} during division; shift one quotient bit into rem.
        rem_sh     = acc_q[ACC_W-1:XLEN-1];
        trial      = rem_sh - {1'b0, opb_q};
        prod_neg   = ~acc_q + ACC_W'(1);
        quo_fix    = neg_q  ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_fix    = rneg_q ? (~acc_q[ACC_W-1:XLEN] + XLEN'(1)) : acc_q[ACC_W-1:XLEN];

        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        araw_d   = araw_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (issue_mul) begin
                    opa_d    = a_mag;
                    opb_d    = b_mag;
                    neg_d    = (op == OP_MULT) && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                    rneg_d   = 1'b0;
                    dz_d     = 1'b0;
                    is_div_d = 1'b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else if (issue_div) begin
                    opa_d    = a_mag;
                    opb_d    = b_mag;
                    araw_d   = rs_val;
                    neg_d    = (op == OP_DIV) && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                    rneg_d   = (op == OP_DIV) && rs_val[XLEN-1];
                    dz_d     = (rt_val == '0);
                    is_div_d = 1'b1;
                    acc_d    = {XLEN'(0), a_mag};
                    cnt_d    = '0;
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            S_MUL: begin
                acc_d = acc_q + mul_addend;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DIV: begin
                if (!trial[XLEN]) begin
                    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIXUP: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                end else if (dz_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        stall = rd_hilo & (state_q != S_IDLE);
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
        rdata = sel_hi ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hilo;
    logic        sel_hi;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .rd_hilo(rd_hilo), .sel_hi(sel_hi),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {hi, lo} from ordinary integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv, ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin qv = 64'(sa * sb); return qv; end
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                qv = ua / ub;
                rv = ua % ub;
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Issue a MULT*/DIV*, follow it to completion, check timing and result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit do_rd, input bit inject_mthi, input bit keep_done);
        logic [63:0] exp;
        logic [31:0] old_hi;
        int n, ns;
        exp    = ref_result(o, a, b);
        old_hi = m_hi;
        start = 1'b1; op = o; rs_val = a; rt_val = b; rd_hilo = do_rd; sel_hi = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_issue", 64'(busy), 64'd1);
        n = 0; ns = 0;
        while (busy && n < 100) begin
            if (stall) ns++;
            if (n == 10) check("hi_held_during_op", 64'(hi), 64'(old_hi));
            if (inject_mthi && n == 5) begin
                start = 1'b1; op = 3'd4; rs_val = 32'hAAAA_5555;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("busy_cycles", 64'(n), 64'd33);
        check("done_pulse", 64'(done), 64'd1);
        check("hi_result", 64'(hi), 64'(m_hi));
        check("lo_result", 64'(lo), 64'(m_lo));
        if (do_rd) begin
            check("stall_cycles", 64'(ns), 64'd33);
            check("stall_in_done", 64'(stall), 64'd0);
            check("rdata_hi_done", 64'(rdata), 64'(m_hi));
            sel_hi = 1'b0;
            #1;
            check("rdata_lo_done", 64'(rdata), 64'(m_lo));
            rd_hilo = 1'b0;
        end
        if (!keep_done) begin
            step();
            check("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    task automatic mt_write(input logic [2:0] o, input logic [31:0] d);
        start = 1'b1; op = o; rs_val = d;
        step();
        start = 1'b0;
        if (o == 3'd4) m_hi = d; else m_lo = d;
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int dn;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        rd_hilo = 1'b0; sel_hi = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        step();

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0);
        check("mult_neg3x5_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'h1);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("mult_m1m1", 64'({hi, lo}), 64'h1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("div_neg7_2", 64'({hi, lo}), 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        check("divu_7_2", 64'({hi, lo}), 64'h0000_0001_0000_0003);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("div_minint", 64'({hi, lo}), 64'h0000_0000_8000_0000);
        run_op(3'd3, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
        check("divu_by_zero", 64'({hi, lo}), 64'h0000_1234_FFFF_FFFF);
        check("no_x_outputs", 64'(^{busy, stall, done, hi, lo, rdata} === 1'bx), 64'd0);

        // Stall on MFHI and MTHI dropped while busy.
        run_op(3'd0, 32'd123_457, 32'hFFFF_0001, 1'b1, 1'b1, 1'b0);
        check("mthi_dropped", 64'(hi == 32'hAAAA_5555), 64'd0);

        // Back-to-back issue in the done cycle.
        run_op(3'd1, 32'd1000, 32'd3000, 1'b0, 1'b0, 1'b1);
        run_op(3'd0, 32'hDEAD_BEEF, 32'h0000_0101, 1'b0, 1'b0, 1'b0);

        // Reset mid-division.
        start = 1'b1; op = 3'd2; rs_val = 32'd1000; rt_val = 32'd7;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            step();
        end
        check("rst_mid_no_done", 64'(dn), 64'd0);

        // MTLO then start together with reset.
        mt_write(3'd5, 32'h5);
        start = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9; reset = 1'b1;
        step();
        start = 1'b0; reset = 1'b0;
        m_lo = '0;
        check("rst_start_lo", 64'(lo), 64'd0);
        check("rst_start_busy", 64'(busy), 64'd0);
        step();
        check("rst_start_idle", 64'(busy), 64'd0);

        // Random mix of operations against the model.
        for (int i = 0; i < 20; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) rb[31] = ra[31] ^ rb[31];
            if (ro < 3'd4) run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            else mt_write(ro, ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
